// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared next-PC select encoding and fetch FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_RSVD   = 2'b11
    } pc_src_e;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_EXEC  = 3'd4,
        FS_ERROR = 3'd5
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/next_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_gen
// Description : Combinational next-PC select with misaligned-target flag.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_source_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] alu_result_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    always_comb begin
        next_pc_o = pc_i + 32'd4;
        case (pc_src_e'(pc_source_i))
            PC_BRANCH: next_pc_o = pc_i + imm_i;
            // jalr clears bit 0 of the computed target
            PC_JALR:   next_pc_o = alu_result_i & ~32'h0000_0001;
            default:   next_pc_o = pc_i + 32'd4;
        endcase
    end

    assign misalign_o = next_pc_o[1];

endmodule : next_pc_gen
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch FSM with PC register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  pc_source_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] alu_result_i,
    input  logic        advance_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  w_next_pc;
    logic         w_next_misalign;

    next_pc_gen u_next_pc_gen (
        .pc_i         (pc_q),
        .pc_source_i  (pc_source_i),
        .imm_i        (imm_i),
        .alu_result_i (alu_result_i),
        .next_pc_o    (w_next_pc),
        .misalign_o   (w_next_misalign)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE:  state_d = FS_REQ;
            FS_REQ:   if (imem_gnt_i)    state_d = FS_WAIT;
            FS_WAIT:  if (imem_rvalid_i) state_d = FS_HOLD;
            FS_HOLD:  if (instr_ready_i) state_d = FS_EXEC;
            FS_EXEC:  if (advance_i)     state_d = w_next_misalign ? FS_ERROR : FS_REQ;
            FS_ERROR: state_d = FS_ERROR;
            default:  state_d = FS_IDLE;
        endcase
    end

    // Datapath registers only move in the one state that owns them
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        if (state_q == FS_WAIT && imem_rvalid_i) begin
            instr_d = imem_rdata_i;
        end
        if (state_q == FS_EXEC && advance_i) begin
            pc_d = w_next_pc;
            if (w_next_misalign) begin
                misalign_d = 1'b1;
            end
        end
    end

    always_comb begin
        imem_req_o    = (state_q == FS_REQ);
        instr_valid_o = (state_q == FS_HOLD);
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + 32'd4;
    assign misalign_o  = misalign_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench: next-PC vector table plus fetch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_source;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_source_i   (pc_source),
        .imm_i         (imm),
        .alu_result_i  (alu_result),
        .advance_i     (advance),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .misalign_o    (misalign)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_advance(input logic [1:0] src, input logic [31:0] im, input logic [31:0] alu);
        pc_source  = src;
        imm        = im;
        alu_result = alu;
        advance    = 1'b1;
        tick();
        advance    = 1'b0;
    endtask

    // Full fetch handshake: gnt after gdly stall cycles, rvalid two cycles after gnt
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input int gdly, input bit poke);
        int   n;
        exp_t e;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        for (int k = 0; k < gdly; k++) begin
            tick();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, exp_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("single_outstanding", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{pc: exp_addr, instr: data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("valid_seen", {31'd0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("instr", instr, e.instr);
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
        if (poke) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~data;
            pc_source   = 2'b10;
            alu_result  = 32'h0000_0800;
            advance     = 1'b1;
            tick();
            imem_rvalid = 1'b0;
            advance     = 1'b0;
            chk("hold_rvalid_ignored", instr, data);
            chk("hold_advance_ignored", pc, exp_addr);
            chk("hold_valid_kept", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        if (poke) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~data;
            tick();
            imem_rvalid = 1'b0;
            chk("exec_rvalid_ignored", instr, data);
            chk("exec_no_req", {31'd0, imem_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{src: 2'b00, imm: 32'h0,         alu: 32'h0,         exp_pc: 32'h0000_0004};
        vecs[1] = '{src: 2'b10, imm: 32'h0,         alu: 32'h0000_0100, exp_pc: 32'h0000_0100};
        vecs[2] = '{src: 2'b01, imm: 32'hFFFF_FFF0, alu: 32'h0,         exp_pc: 32'h0000_00F0};
        vecs[3] = '{src: 2'b10, imm: 32'h0,         alu: 32'h0000_0205, exp_pc: 32'h0000_0204};
        vecs[4] = '{src: 2'b11, imm: 32'h0000_0040, alu: 32'h0000_0800, exp_pc: 32'h0000_0208};
        vecs[5] = '{src: 2'b01, imm: 32'h0000_0010, alu: 32'h0,         exp_pc: 32'h0000_0218};
        vecs[6] = '{src: 2'b10, imm: 32'h0,         alu: 32'hFFFF_FFFD, exp_pc: 32'hFFFF_FFFC};
        vecs[7] = '{src: 2'b00, imm: 32'h0,         alu: 32'h0,         exp_pc: 32'h0000_0000};
        vecs[8] = '{src: 2'b01, imm: 32'h0000_0020, alu: 32'h0,         exp_pc: 32'h0000_0020};

        rst = 1'b1; pc_source = 2'b00; imm = 32'h0; alu_result = 32'h0; advance = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        repeat (3) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;
        tick();

        do_fetch(32'h0, 32'h0050_0093, 0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_advance(vecs[i].src, vecs[i].imm, vecs[i].alu);
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_pc);
            chk($sformatf("vec%0d_misalign", i), {31'd0, misalign}, 32'd0);
            do_fetch(vecs[i].exp_pc, $urandom, (i == 3) ? 5 : 0, (i == 1));
        end

        // Misaligned jalr target: sticky error, no requests until reset
        do_advance(2'b10, 32'h0, 32'h0000_0206);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_pc", pc, 32'h0000_0206);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            advance   = (k == 0);
            pc_source = 2'b00;
            imem_gnt  = (k == 3);
            tick();
            advance   = 1'b0;
            imem_gnt  = 1'b0;
            chk("err_no_req", {31'd0, imem_req}, 32'd0);
            chk("err_sticky", {31'd0, misalign}, 32'd1);
        end
        chk("err_pc_held", pc, 32'h0000_0206);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_rst_misalign", {31'd0, misalign}, 32'd0);
        chk("err_rst_pc", pc, 32'h0);
        tick();

        // Reset during WAIT, then a stale response after release
        chk("w_req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_instr", instr, 32'h0000_0013);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_instr_req", instr, 32'h0000_0013);
        do_fetch(32'h0, 32'h0010_0113, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have these ports: clk_i  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port pc_source_i  in  2  next-PC select: 00 = PC+4, 01 = PC+imm (branch taken or jal), 10 = jalr target, 11 = reserved.
REQ-005 The block SHALL have port imm_i  in  32  sign-extended branch/jal offset.
REQ-006 The block SHALL have port alu_result_i  in  32  jalr target before alignment.
REQ-007 The block SHALL have port advance_i  in  1  one-cycle pulse; pc_source_i, imm_i and alu_result_i are valid with it.
REQ-008 The block SHALL have port imem_req_o  out  1  instruction-memory request.
REQ-009 The block SHALL have port imem_addr_o  out  32  request address.
REQ-010 The block SHALL have port imem_gnt_i  in  1  request accepted.
REQ-011 The block SHALL have port imem_rvalid_i  in  1  read data valid.
REQ-012 The block SHALL have port imem_rdata_i  in  32  read data.
REQ-013 The block SHALL have port instr_o  out  32  fetched instruction, held stable while instr_valid_o=1.
REQ-014 The block SHALL have port instr_valid_o  out  1  instruction offered to the core.
REQ-015 The block SHALL have port instr_ready_i  in  1  core accepts the instruction.
REQ-016 The block SHALL have port pc_o  out  32  PC of the current instruction.
REQ-017 The block SHALL have port pc_plus4_o  out  32  pc_o+4 (link value).
REQ-018 The block SHALL have port misalign_o  out  1  sticky misaligned-target error.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, EXEC and ERROR.
REQ-020 IDLE SHALL go to REQ after one cycle.
REQ-021 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL equal pc_o; both SHALL be held until imem_gnt_i=1, then the FSM SHALL go to WAIT.
REQ-022 In WAIT, on imem_rvalid_i=1 the block SHALL register imem_rdata_i into instr_o and go to HOLD.
REQ-023 A grant-to-rvalid latency of zero is not supported; rvalid SHALL arrive at least 1 cycle after gnt.
REQ-024 In HOLD, instr_valid_o SHALL be 1; when instr_ready_i=1 the block SHALL go to EXEC, and instr_valid_o SHALL drop the next cycle.
REQ-025 In EXEC, on advance_i=1 the next PC SHALL be computed, registered into pc_o, and the FSM SHALL go to REQ the following cycle.
REQ-026 The next PC SHALL be: source 00 → pc_o+4; source 01 → pc_o+imm_i; source 10 → {alu_result_i[31:1],1'b0}; source 11 → treated as 00.
REQ-027 Next-PC additions SHALL be 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-028 If the next PC has bit[1]=1, pc_o SHALL still load the value, misalign_o SHALL set, and the FSM SHALL enter ERROR.
REQ-029 ERROR SHALL be exited only by reset, and no request SHALL be issued while in ERROR.
REQ-030 advance_i outside EXEC SHALL be ignored.
REQ-031 imem_rvalid_i outside WAIT SHALL be ignored, including a stale response arriving after reset.
REQ-032 A single imem transaction SHALL be outstanding at a time.
REQ-033 pc_plus4_o SHALL be combinational from pc_o.

Reset
REQ-034 While rst_i=1 at a rising edge, the state SHALL become IDLE.
REQ-035 Reset SHALL set pc_o=RESET_PC, instr_o=32'h0000_0013 (nop), instr_valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC and misalign_o=0.
REQ-036 Reset SHALL abort any in-flight transaction from any state.

Structure
REQ-037 The pc_source encoding (PC_PLUS4, PC_BRANCH, PC_JALR) and the fetch state enum SHALL live in the shared package riscv_pkg.
REQ-038 The next-PC computation SHALL be the combinational sub-module next_pc_gen; the FSM and registers SHALL remain in fetch_unit.

Verification
REQ-039 Reset release with RESET_PC=0, gnt on the 1st cycle of REQ, rvalid 2 cycles later with data 32'h00500093 → instr_o=32'h00500093, instr_valid_o=1, pc_o=0.
REQ-040 Accept instruction, then advance_i with source 00 → next imem_addr_o=32'h4 with imem_req_o=1.
REQ-041 pc_o=32'h100, source 01, imm_i=32'hFFFF_FFF0 → imem_addr_o=32'h0F0; with source 10 and alu_result_i=32'h205 → imem_addr_o=32'h204.
REQ-042 Source 10 with alu_result_i=32'h206 → misalign_o=1, ERROR state, imem_req_o stays 0 across 10 cycles; reset clears the error.
REQ-043 gnt withheld for 5 cycles → imem_req_o and imem_addr_o remain stable; rvalid pulse during EXEC or HOLD → instr_o unchanged.
REQ-044 rst_i asserted in WAIT, then stale rvalid after release → ignored; first fetch is from RESET_PC.
